// File: rtl/pc_gen_pkg.sv
// Shared defaults and state encoding for the program-counter generator.
package pc_gen_pkg;
  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;
endpackage

// File: rtl/pc_adder.sv
// Plain XLEN-wide modulo adder used for both redirect target computations.
module pc_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential advance, branch/JALR redirect,
// redirect holding across stalls, and misaligned-target trapping.
//
//   state | meaning
//   RUN   | no redirect outstanding; pc advances or redirects when not stalled
//   HOLD  | a redirect arrived under stall; target kept until stall releases
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            take_branch,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_target,
  output logic            redirect_pending,
  output logic            misalign
);

  pc_state_e       state, state_nxt;
  logic [XLEN-1:0] held_tgt, held_tgt_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] br_sum, jalr_sum;
  logic [XLEN-1:0] load_val;
  logic            load;
  logic            misalign_nxt;
  logic            redirect;

  pc_adder #(.XLEN(XLEN)) u_br_add (
    .a   (pc),
    .b   (imm_ext),
    .sum (br_sum)
  );

  pc_adder #(.XLEN(XLEN)) u_jalr_add (
    .a   (rs1_val),
    .b   (imm_ext),
    .sum (jalr_sum)
  );

  assign pc_plus4         = pc + XLEN'(4);
  assign redirect         = jalr | take_branch;
  assign pc_target        = jalr ? (jalr_sum & ~XLEN'(1)) : br_sum;
  assign redirect_pending = (state == HOLD);

  always_comb begin
    state_nxt    = state;
    held_tgt_nxt = held_tgt;
    load         = 1'b0;
    load_val     = pc_target;
    pc_nxt       = pc;
    misalign_nxt = 1'b0;

    case (state)
      RUN: begin
        if (!stall) begin
          if (redirect) load = 1'b1;
          else          pc_nxt = pc_plus4;
        end else if (redirect) begin
          held_tgt_nxt = pc_target;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (redirect) held_tgt_nxt = pc_target;
        end else begin
          load      = 1'b1;
          load_val  = redirect ? pc_target : held_tgt;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    // Alignment is judged on the value actually applied, not when it was held.
    if (load) begin
      misalign_nxt = |load_val[1:0];
      pc_nxt       = misalign_nxt ? TRAP_VEC : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_VEC;
      held_tgt <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      held_tgt <= held_tgt_nxt;
      misalign <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// against a behavioural model of the PC sequencing rules.
module tb_pc_gen;
  localparam logic [31:0] RST_V  = 32'h0000_0000;
  localparam logic [31:0] TRAP_V = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, take_branch, jalr;
  logic [31:0] imm_ext, rs1_val;
  logic [31:0] pc, pc_plus4, pc_target;
  logic        redirect_pending, misalign;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_held;
  logic        m_mis;

  // values captured before the edge of the last step
  logic [31:0] obs_target, exp_target, obs_plus4, exp_plus4;

  pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .take_branch      (take_branch),
    .jalr             (jalr),
    .imm_ext          (imm_ext),
    .rs1_val          (rs1_val),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .pc_target        (pc_target),
    .redirect_pending (redirect_pending),
    .misalign         (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_target(input logic j, input logic [31:0] imm,
                                               input logic [31:0] rs1, input logic [31:0] cur_pc);
    logic [31:0] t;
    if (j) begin
      t = rs1 + imm;
      t[0] = 1'b0;
    end else begin
      t = cur_pc + imm;
    end
    return t;
  endfunction

  task automatic model_apply(input logic [31:0] t);
    if (t[1:0] != 2'b00) begin
      m_pc  = TRAP_V;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  // Drive one cycle of inputs, capture combinational outputs, clock, update model.
  task automatic step(input logic r, input logic s, input logic b, input logic j,
                      input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    rst = r; stall = s; take_branch = b; jalr = j; imm_ext = imm; rs1_val = rs1;
    #1;
    t          = model_target(j, imm, rs1, m_pc);
    exp_target = t;
    exp_plus4  = m_pc + 32'd4;
    obs_target = pc_target;
    obs_plus4  = pc_plus4;
    @(posedge clk);
    if (r) begin
      m_pc = RST_V; m_pend = 1'b0; m_held = '0; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (s) begin
        if (b | j) begin
          m_pend = 1'b1;
          m_held = t;
        end
      end else begin
        if (b | j)       model_apply(t);
        else if (m_pend) model_apply(m_held);
        else             m_pc = m_pc + 32'd4;
        m_pend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, a);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h6, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h3);
    total++; if (pc !== RST_V) begin bad++; $display("FAIL reset_pc got %h exp %h", pc, RST_V); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL reset_pend got %b exp 0", redirect_pending); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL reset_mis got %b exp 0", misalign); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_plus4 !== 32'h4) begin bad++; $display("FAIL reset_plus4 got %h exp %h", obs_plus4, 32'h4); end
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL reset_adv got %h exp %h", pc, 32'h4); end
  endtask

  task automatic test_branch;
    goto_pc(32'h10);
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL goto got %h exp %h", pc, 32'h10); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h14, 32'hDEAD_BEE0);
    total++; if (obs_target !== 32'h24) begin bad++; $display("FAIL br_target got %h exp %h", obs_target, 32'h24); end
    total++; if (pc !== 32'h24) begin bad++; $display("FAIL br_pc got %h exp %h", pc, 32'h24); end
    // backward branch with negative immediate
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL br_neg got %h exp %h", pc, 32'h14); end
  endtask

  task automatic test_jalr;
    goto_pc(32'h200);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0001_0451);
    total++; if (obs_target !== 32'h0001_0460) begin bad++; $display("FAIL jalr_target got %h exp %h", obs_target, 32'h0001_0460); end
    total++; if (pc !== 32'h0001_0460) begin bad++; $display("FAIL jalr_pc got %h exp %h", pc, 32'h0001_0460); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL jalr_mis got %b exp 0", misalign); end
  endtask

  task automatic test_stall_redirect;
    goto_pc(32'h20);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h54, 32'h0);
    total++; if (obs_target !== 32'h74) begin bad++; $display("FAIL st_target got %h exp %h", obs_target, 32'h74); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
      total++; if (obs_target !== 32'h28) begin bad++; $display("FAIL st_live_target got %h exp %h", obs_target, 32'h28); end
    end
    total++; if (pc !== 32'h20) begin bad++; $display("FAIL st_hold_pc got %h exp %h", pc, 32'h20); end
    total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL st_pend got %b exp 1", redirect_pending); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (pc !== 32'h74) begin bad++; $display("FAIL st_release got %h exp %h", pc, 32'h74); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL st_clear got %b exp 0", redirect_pending); end
  endtask

  task automatic test_newest_wins;
    goto_pc(32'h1000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h3000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (pc !== 32'h3008) begin bad++; $display("FAIL newest got %h exp %h", pc, 32'h3008); end
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
    total++; if (pc !== 32'h3088) begin bad++; $display("FAIL release_new got %h exp %h", pc, 32'h3088); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL release_new_pend got %b exp 0", redirect_pending); end
  endtask

  task automatic test_misalign;
    goto_pc(32'h10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h6, 32'h0);
    total++; if (pc !== TRAP_V) begin bad++; $display("FAIL mis_pc got %h exp %h", pc, TRAP_V); end
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_pulse got %b exp 1", misalign); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_one_cycle got %b exp 0", misalign); end
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL mis_next got %h exp %h", pc, 32'h104); end
    // misaligned target latched under stall traps only when applied
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h2, 32'h500);
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_latch got %b exp 0", misalign); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (pc !== TRAP_V) begin bad++; $display("FAIL mis_held_pc got %h exp %h", pc, TRAP_V); end
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_held got %b exp 1", misalign); end
  endtask

  task automatic test_wrap;
    goto_pc(32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (obs_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got %h exp %h", obs_plus4, 32'h0); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); end
  endtask

  task automatic test_reset_hold;
    goto_pc(32'h40);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL rh_pend got %b exp 1", redirect_pending); end
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    total++; if (pc !== RST_V) begin bad++; $display("FAIL rh_pc got %h exp %h", pc, RST_V); end
    total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL rh_clear got %b exp 0", redirect_pending); end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (pc !== RST_V + 32'd4) begin bad++; $display("FAIL rh_adv got %h exp %h", pc, RST_V + 32'd4); end
  endtask

  task automatic test_random;
    logic r, s, b, j;
    logic [31:0] imm, rs1;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 39) == 0);
      s   = ($urandom_range(0, 2) == 0);
      b   = ($urandom_range(0, 3) == 0);
      j   = ($urandom_range(0, 5) == 0);
      imm = $urandom;
      rs1 = $urandom;
      if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) rs1[1:0] = 2'b00;
      step(r, s, b, j, imm, rs1);
      total++; if (obs_target !== exp_target) begin bad++; $display("FAIL rnd_target[%0d] got %h exp %h", i, obs_target, exp_target); end
      total++; if (obs_plus4 !== exp_plus4) begin bad++; $display("FAIL rnd_plus4[%0d] got %h exp %h", i, obs_plus4, exp_plus4); end
      total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, pc, m_pc); end
      total++; if (redirect_pending !== m_pend) begin bad++; $display("FAIL rnd_pend[%0d] got %b exp %b", i, redirect_pending, m_pend); end
      total++; if (misalign !== m_mis) begin bad++; $display("FAIL rnd_mis[%0d] got %b exp %b", i, misalign, m_mis); end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; take_branch = 1'b0; jalr = 1'b0;
    imm_ext = '0; rs1_val = '0;
    m_pc = RST_V; m_pend = 1'b0; m_held = '0; m_mis = 1'b0;
    test_reset;
    test_branch;
    test_jalr;
    test_stall_redirect;
    test_newest_wins;
    test_misalign;
    test_wrap;
    test_reset_hold;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
